// File: rtl/wshb_prio_arbiter.sv
// Two-master Wishbone arbiter: master 0 has priority, master 1 is protected by a starvation timer.
// Optional grant/starve statistics counters are enabled with `define WSHB_ARB_STATS_EN.
module wshb_prio_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADR_W    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADR_W-1:0]    m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_ms,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_dat_sm,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADR_W-1:0]    m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_ms,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_dat_sm,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADR_W-1:0]    s_adr,
  output logic [DATA_W-1:0]   s_dat_ms,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_dat_sm,
`ifdef WSHB_ARB_STATS_EN
  output logic [15:0]         gnt0_cnt,
  output logic [15:0]         gnt1_cnt,
  output logic [15:0]         starve_cnt,
`endif
  output logic [1:0]          gnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       arb;
  logic [CNT_W-1:0] wait_cnt;
  logic             starve;

  assign starve = (wait_cnt == WAIT_MAX);

  always_comb begin
    if (starve && m1_cyc)  arb = GNT1;
    else if (m0_cyc)       arb = GNT0;
    else if (m1_cyc)       arb = GNT1;
    else                   arb = IDLE;
  end

  // The owner keeps the bus until it drops cyc; only then is arb() consulted.
  always_comb begin
    case (state)
      GNT0:    state_nxt = m0_cyc ? GNT0 : arb;
      GNT1:    state_nxt = m1_cyc ? GNT1 : arb;
      default: state_nxt = arb;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!m1_cyc || (state != GNT1 && state_nxt == GNT1))
        wait_cnt <= '0;
      else if (state != GNT1 && !starve)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign gnt       = {state == GNT1, state == GNT0};

`ifdef WSHB_ARB_STATS_EN
  logic starve_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt0_cnt   <= '0;
      gnt1_cnt   <= '0;
      starve_cnt <= '0;
      starve_q   <= 1'b0;
    end else begin
      starve_q <= starve;
      if (state != GNT0 && state_nxt == GNT0 && gnt0_cnt != 16'hFFFF)
        gnt0_cnt <= gnt0_cnt + 16'd1;
      if (state != GNT1 && state_nxt == GNT1 && gnt1_cnt != 16'hFFFF)
        gnt1_cnt <= gnt1_cnt + 16'd1;
      if (starve && !starve_q && starve_cnt != 16'hFFFF)
        starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wshb_prio_arbiter.sv
// Self-checking bench for wshb_prio_arbiter: directed scenarios plus randomized traffic
// compared each cycle against an owner/wait-count model of the arbitration rules.
module tb_wshb_prio_arbiter;

  localparam int MAXW = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = '0, m0_dat_ms = '0;
  logic [3:0]  m0_sel = '0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = '0, m1_dat_ms = '0;
  logic [3:0]  m1_sel = '0;
  logic        s_ack = 0;
  logic [31:0] s_dat_sm = '0;
  logic        m0_ack, m1_ack, s_cyc, s_stb, s_we;
  logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
`ifdef WSHB_ARB_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt, starve_cnt;
`endif

  wshb_prio_arbiter #(.DATA_W(32), .ADR_W(32), .MAX_WAIT(MAXW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
`ifdef WSHB_ARB_STATS_EN
    .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .starve_cnt(starve_cnt),
`endif
    .gnt(gnt)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 (nobody), 0 or 1; wt is how long master 1 has been kept waiting.
  int owner = -1;
  int wt    = 0;
  int g0_m = 0, g1_m = 0, st_m = 0;
  bit st_prev = 0;

  function automatic int next_owner(int own, logic c0, logic c1, int w);
    if (own == 0 && c0) return 0;
    if (own == 1 && c1) return 1;
    if (w >= MAXW && c1) return 1;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  function automatic int next_wait(int own, logic c0, logic c1, int w);
    int n;
    n = next_owner(own, c0, c1, w);
    if (!c1 || (own != 1 && n == 1)) return 0;
    if (own == 1) return w;
    return (w + 1 > MAXW) ? MAXW : w + 1;
  endfunction

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      owner <= -1; wt <= 0; g0_m <= 0; g1_m <= 0; st_m <= 0; st_prev <= 0;
    end else begin
      owner   <= next_owner(owner, m0_cyc, m1_cyc, wt);
      wt      <= next_wait(owner, m0_cyc, m1_cyc, wt);
      st_prev <= (wt >= MAXW);
      if (owner != 0 && next_owner(owner, m0_cyc, m1_cyc, wt) == 0) g0_m <= g0_m + 1;
      if (owner != 1 && next_owner(owner, m0_cyc, m1_cyc, wt) == 1) g1_m <= g1_m + 1;
      if (wt >= MAXW && !st_prev) st_m <= st_m + 1;
    end
  end

  // Per-cycle comparison of every output against what the model owner implies.
  always @(negedge sys_clk) begin
    if (checking) begin
      logic [2:0]  e_ctl;
      logic [67:0] e_bus;
      logic [1:0]  e_ack, e_gnt;
      e_ctl = 3'b000; e_bus = '0; e_ack = 2'b00; e_gnt = 2'b00;
      if (owner == 0) begin
        e_ctl = {m0_cyc, m0_stb, m0_we}; e_bus = {m0_adr, m0_dat_ms, m0_sel};
        e_ack = {1'b0, s_ack}; e_gnt = 2'b01;
      end else if (owner == 1) begin
        e_ctl = {m1_cyc, m1_stb, m1_we}; e_bus = {m1_adr, m1_dat_ms, m1_sel};
        e_ack = {s_ack, 1'b0}; e_gnt = 2'b10;
      end
      check("ctl_gnt_ack", {s_cyc, s_stb, s_we, gnt, m1_ack, m0_ack}, {e_ctl, e_gnt, e_ack});
      check("slave_bus", {s_adr, s_dat_ms, s_sel}, e_bus);
      check("rd_data", {m0_dat_sm, m1_dat_sm}, {s_dat_sm, s_dat_sm});
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc);
    m0_cyc = cyc; m0_stb = cyc; m0_we = 1'b0;
    m0_adr = 32'h0000_1000; m0_dat_ms = 32'h1111_1111; m0_sel = 4'hF;
  endtask

  task automatic set_m1(input logic cyc);
    m1_cyc = cyc; m1_stb = cyc; m1_we = 1'b1;
    m1_adr = 32'h0000_2000; m1_dat_ms = 32'h2222_2222; m1_sel = 4'h3;
  endtask

  initial begin
    // Reset for three cycles, then idle.
    repeat (3) step();
    sys_rst = 1'b0;
    checking = 1;
    @(negedge sys_clk);
    check("reset_idle", {s_cyc, gnt, m0_ack, m1_ack}, 5'b0);

    // Single master 0 read with a late slave ack.
    step(); set_m0(1);
    step(); @(negedge sys_clk);
    check("m0_s_cyc_latency", {s_cyc, gnt}, 3'b1_01);
    check("m0_adr", s_adr, 32'h0000_1000);
    step(); step();
    s_ack = 1'b1; s_dat_sm = 32'hCAFE_F00D;
    @(negedge sys_clk);
    check("m0_ack_data", {m0_ack, m1_ack, m0_dat_sm}, {2'b10, 32'hCAFE_F00D});
    step(); s_ack = 1'b0; set_m0(0);
    step(); @(negedge sys_clk);
    check("back_to_idle", {s_cyc, gnt}, 3'b0_00);

    // Simultaneous request: master 0 wins, handover to master 1 with no gap.
    step(); set_m0(1); set_m1(1);
    step(); @(negedge sys_clk);
    check("simul_gnt0", gnt, 2'b01);
    s_ack = 1'b1;
    repeat (4) step();
    s_ack = 1'b0; set_m0(0);
    step(); @(negedge sys_clk);
    check("handover_gnt1", {gnt, s_cyc, s_we}, 4'b10_1_1);
    step(); set_m1(0);
    step(); @(negedge sys_clk);
    check("idle_again", gnt, 2'b00);

    // Starvation: master 0 holds for 20 cycles while master 1 waits.
    step(); set_m0(1); set_m1(1);
    repeat (20) step();
    @(negedge sys_clk);
    check("no_preempt", gnt, 2'b01);
    check("model_wait_sat", wt, MAXW);
    step(); set_m0(0);
    step(); set_m0(1);
    @(negedge sys_clk);
    check("starve_gnt1", gnt, 2'b10);
    check("model_wait_clr", wt, 0);
    step(); step(); @(negedge sys_clk);
    check("gnt1_held", gnt, 2'b10);

    // Reset pulse while master 1 owns the bus and the slave is acking.
    s_ack = 1'b1;
    step(); sys_rst = 1'b1;
    step(); sys_rst = 1'b0; set_m0(0); set_m1(0);
    @(negedge sys_clk);
    check("rst_mid_cycle", {gnt, s_cyc, m1_ack, m0_ack}, 5'b0);
    s_ack = 1'b0;

    // Randomized traffic checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        sys_rst = 1'b1; m0_cyc = 0; m1_cyc = 0;
      end else begin
        sys_rst = 1'b0;
        m0_cyc = m0_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
        m1_cyc = m1_cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
      end
      m0_stb = m0_cyc & 1'($urandom); m0_we = 1'($urandom);
      m0_adr = $urandom; m0_dat_ms = $urandom; m0_sel = 4'($urandom);
      m1_stb = m1_cyc & 1'($urandom); m1_we = 1'($urandom);
      m1_adr = $urandom; m1_dat_ms = $urandom; m1_sel = 4'($urandom);
      s_ack = 1'($urandom); s_dat_sm = $urandom;
    end
    step(); sys_rst = 1'b0;
    @(negedge sys_clk);
`ifdef WSHB_ARB_STATS_EN
    check("stats", {gnt0_cnt, gnt1_cnt, starve_cnt}, {16'(g0_m), 16'(g1_m), 16'(st_m)});
`endif
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wshb_prio_arbiter.md
Name: wshb_prio_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter sharing the SDRAM slave port between the VGA frame reader (master 0, high priority) and the pattern/stream writer (master 1, low priority).
- Sits between the video masters and the SDRAM controller in the sys_clk domain.
- Grant is registered and changes only at cycle boundaries (owner drops cyc).
- A starvation timer guarantees master 1 the next grant after MAX_WAIT cycles of waiting.

Parameters:
- DATA_W, 32: data bus width.
- ADR_W, 32: address bus width.
- MAX_WAIT, 64: cycles master 1 may wait with cyc high before it gets priority at the next arbitration point; must be ≥1.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  synchronous active-high reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (VGA) control.
- m0_adr  in  ADR_W  master 0 address.
- m0_dat_ms  in  DATA_W  master 0 write data.
- m0_sel  in  DATA_W/8  master 0 byte select.
- m0_ack  out  1  master 0 acknowledge.
- m0_dat_sm  out  DATA_W  master 0 read data.
- m1_*  same set as m0_*, for master 1 (stream/mire).
- s_cyc, s_stb, s_we  out  1 each  slave-side control.
- s_adr  out  ADR_W  slave-side address.
- s_dat_ms  out  DATA_W  slave-side write data.
- s_sel  out  DATA_W/8  slave-side byte select.
- s_ack  in  1  slave acknowledge.
- s_dat_sm  in  DATA_W  slave read data.
- gnt  out  2  one-hot current grant; 00 = idle.

Behaviour:
- States: IDLE, GNT0, GNT1. Reset (sys_rst=1 at a clock edge) forces IDLE, starvation counter=0, starve flag=0.
- Arbitration function arb(m0_cyc, m1_cyc, starve):
  - starve & m1_cyc → GNT1.
  - else m0_cyc → GNT0.
  - else m1_cyc → GNT1.
  - else IDLE.
- Transitions:
  - IDLE → arb(...) every cycle.
  - GNTx holds while mx_cyc=1.
  - On the first cycle where mx_cyc=0, the next state is arb(...) evaluated that cycle. Back-to-back handover therefore costs no idle cycle.
- Latency: a request on an idle bus appears on s_cyc/s_stb exactly 1 cycle after mx_cyc rises.
- Routing (combinational from the registered state):
  - s_* = granted master's signals.
  - In IDLE: s_cyc=s_stb=s_we=0, s_adr/s_dat_ms/s_sel=0.
  - mx_ack = s_ack & (state==GNTx); a non-granted master never sees ack.
  - m0_dat_sm = m1_dat_sm = s_dat_sm (broadcast, qualified by ack).
- Starvation counter:
  - Increments each cycle m1_cyc=1 and state≠GNT1; saturates at MAX_WAIT.
  - starve=1 when the counter reaches MAX_WAIT.
  - Counter and starve clear on entry to GNT1, or when m1_cyc=0.
- No preemption: an owner is never cut off mid-cycle. starve only affects the next arbitration point.
- Simultaneous cyc rise from IDLE: master 0 wins unless starve=1.
- Reset during an active cycle:
  - s_cyc=0 on the following cycle.
  - Pending ack is not forwarded.
  - Masters are also reset by sys_rst.
- Outputs after reset: all s_* 0, m0_ack=m1_ack=0, gnt=00. mx_dat_sm follows s_dat_sm.

Optional Feature:
- Macro WSHB_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt0_cnt[15:0], gnt1_cnt[15:0] and starve_cnt[15:0].
  - Each counts grant entries or starve assertions (0→1 edge), saturating at 0xFFFF, reset to 0 by sys_rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then idle: sys_rst for 3 cycles → s_cyc=0, gnt=00, both acks 0.
- Single master 0 read: m0_cyc/stb rise at t → s_cyc=1 at t+1; slave ack after 2 cycles → m0_ack=1 and m0_dat_sm=0xCAFEF00D; m1_ack stays 0.
- Simultaneous request: m0_cyc and m1_cyc rise the same cycle, counter 0 → GNT0. m0 drops cyc after 4 acks → gnt=10 (GNT1) on the next cycle with no idle gap.
- Starvation with MAX_WAIT=8: m0 holds cyc for 20 cycles, m1 requesting throughout → starve=1 at wait count 8. m0 drops, then m0 re-requests the same cycle m1 is still up → GNT1 wins. Counter clears.
- Reset mid-cycle: GNT1 active, sys_rst pulses 1 cycle → next cycle gnt=00, s_cyc=0, m1_ack=0 even with s_ack=1.
- Stats (WSHB_ARB_STATS_EN): 5 m0 cycles, 3 m1 cycles, 1 starve event → gnt0_cnt=5, gnt1_cnt=3, starve_cnt=1.
